// File: rtl/lcd_cmd_issuer_if.sv
// Host-side handshake and controller command bus of the LCD command issuer.
//   host_cmd/host_valid/host_ready : opcode transfer from the host
//   busy/done                      : status from the LCD image controller
//   cmd/cmd_valid                  : opcode issue strobe to the controller
// master = host/controller side, slave = lcd_cmd_issuer.
interface lcd_cmd_issuer_if;
   logic [3:0] host_cmd;
   logic       host_valid;
   logic       host_ready;
   logic       busy;
   logic       done;
   logic [3:0] cmd;
   logic       cmd_valid;

   modport master (
      output host_cmd, host_valid, busy, done,
      input  host_ready, cmd, cmd_valid
   );

   modport slave (
      input  host_cmd, host_valid, busy, done,
      output host_ready, cmd, cmd_valid
   );
endinterface

// File: rtl/lcd_cmd_issuer.sv
// Command front-end for the LCD image controller. Buffers legal host opcodes
// in a circular FIFO and issues them one at a time while the controller is
// idle. Opcode 0 (write-out) flushes the queue and waits for done.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   bus        : host handshake + controller cmd/busy/done (slave modport)
//   issued_cnt : saturating count of issued commands
//   drop_cnt   : saturating count of dropped illegal opcodes (8..15)
//   err        : sticky acknowledge-timeout flag
//   finished   : set once done is seen after the write-out command
module lcd_cmd_issuer #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic                clk,
   input  logic                rst,
   lcd_cmd_issuer_if.slave     bus,
   output logic [7:0]          issued_cnt,
   output logic [7:0]          drop_cnt,
   output logic                err,
   output logic                finished
);

   localparam int unsigned CW     = AW + 1;
   localparam int unsigned ACK_TO = 4;
   localparam int unsigned TW     = 2;
   localparam logic [3:0]  NOP    = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_FINISH
   } state_t;

   state_t         state_q, state_d;
   logic [3:0]     mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;
   logic [3:0]     cmd_q, cmd_d;
   logic           cmd_valid_q, cmd_valid_d;
   logic [7:0]     issued_q, issued_d, drop_q, drop_d;
   logic           err_q, err_d, fin_q, fin_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic           host_ready_c, xfer_c, push_c, pop_c, flush_c;

   // Ready is decoded from registered state/count, so a pop never frees a slot early
   assign host_ready_c = (count_q != CW'(DEPTH)) &&
                         (state_q == S_IDLE || state_q == S_ISSUE || state_q == S_WAIT_ACK);
   assign xfer_c = bus.host_valid && host_ready_c;
   assign push_c = xfer_c && !bus.host_cmd[3];

   // Next-state, FIFO bookkeeping and output decode
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      cmd_d       = cmd_q;
      cmd_valid_d = cmd_valid_q;
      issued_d    = issued_q;
      drop_d      = drop_q;
      err_d       = err_q;
      fin_d       = fin_q;
      tmr_d       = tmr_q;
      pop_c       = 1'b0;
      flush_c     = 1'b0;

      if (xfer_c && bus.host_cmd[3] && drop_q != 8'hFF)
         drop_d = drop_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (count_q != '0 && !bus.busy) begin
               pop_c       = 1'b1;
               cmd_d       = mem_q[rd_ptr_q];
               cmd_valid_d = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cmd_valid_d = 1'b0;
            cmd_d       = NOP;
            if (issued_q != 8'hFF)
               issued_d = issued_q + 8'd1;
            // cmd_q still holds the opcode that was just issued
            if (cmd_q == 4'd0) begin
               flush_c = 1'b1;
               state_d = S_WAIT_DONE;
            end else begin
               tmr_d   = '0;
               state_d = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (bus.busy) begin
               state_d = S_IDLE;
            end else if (tmr_q == TW'(ACK_TO - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         S_WAIT_DONE: begin
            if (bus.done) begin
               fin_d   = 1'b1;
               state_d = S_FINISH;
            end
         end
         S_FINISH: fin_d = 1'b1;
         default:  state_d = S_IDLE;
      endcase

      // Flush after write-out discards everything, including a same-cycle push
      if (flush_c) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (push_c && !pop_c)      count_d = count_q + CW'(1);
         else if (!push_c && pop_c) count_d = count_q - CW'(1);
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         cmd_q       <= NOP;
         cmd_valid_q <= 1'b0;
         issued_q    <= '0;
         drop_q      <= '0;
         err_q       <= 1'b0;
         fin_q       <= 1'b0;
         tmr_q       <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         issued_q    <= issued_d;
         drop_q      <= drop_d;
         err_q       <= err_d;
         fin_q       <= fin_d;
         tmr_q       <= tmr_d;
      end
   end

   // FIFO storage; contents need no reset since count gates every read
   always_ff @(posedge clk) begin
      if (rst && push_c)
         mem_q[wr_ptr_q] <= bus.host_cmd;
   end

   assign bus.host_ready = host_ready_c;
   assign bus.cmd        = cmd_q;
   assign bus.cmd_valid  = cmd_valid_q;
   assign issued_cnt     = issued_q;
   assign drop_cnt       = drop_q;
   assign err            = err_q;
   assign finished       = fin_q;

endmodule
